// File: rtl/decoder_pkg.sv
// Shared constants and bundles for the BCD one-hot decoder slice.
// Holds the BCD digit limit, index width, default prefix and S1 bundle.
package decoder_pkg;

  localparam int BCD_MAX = 9;
  localparam int IDX_W   = 7;

  localparam logic [7:0] DEF_PREFIX = 8'h01;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
  } s1_t;

endpackage

// File: rtl/bcd_onehot_decoder_pipe_bcd2bin.sv
// bcd2bin: combinational two-digit BCD to 7-bit binary converter.
// Ports: tens/units (BCD digits) in; bin (tens*10+units), digit_ok out.
module bcd2bin
  import decoder_pkg::*;
(
  input  logic [3:0]       tens,
  input  logic [3:0]       units,
  output logic [IDX_W-1:0] bin,
  output logic             digit_ok
);

  localparam logic [3:0] LIM = 4'(BCD_MAX);

  assign digit_ok = (tens <= LIM) && (units <= LIM);

  // tens*10 as tens*8 + tens*2; only meaningful when digit_ok
  assign bin = {tens, 3'b000}
             + {2'b00, tens, 1'b0}
             + {3'b000, units};

endmodule

// File: rtl/bcd_onehot_decoder_pipe.sv
// Two-stage pipelined prefixed-BCD to one-hot decoder with error count.
// Ports: clk, reset (sync, high); in_valid/in_ready/d input handshake;
// out_valid/out_ready/q/err output handshake; err_cnt saturating count.
module bcd_onehot_decoder_pipe
  import decoder_pkg::*;
#(
  parameter logic [7:0] PREFIX  = DEF_PREFIX,
  parameter int         N_CODES = 23,
  parameter int         CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_CODES-1:0] q,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [IDX_W-1:0] NC_LIM =
    IDX_W'(N_CODES);

  logic             s1_valid;
  s1_t              s1;
  logic             s1_adv;
  logic [IDX_W-1:0] bin;
  logic             digit_ok;
  logic             code_ok;
  logic             in_acc;
  logic [N_CODES-1:0] q_nx;

  bcd2bin u_b2b (
    .tens     (d[7:4]),
    .units    (d[3:0]),
    .bin      (bin),
    .digit_ok (digit_ok)
  );

  assign code_ok = (d[15:8] == PREFIX)
                && digit_ok
                && (bin < NC_LIM);

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign in_acc   = in_valid && in_ready;

  always_comb begin
    q_nx = '0;
    for (int i = 0; i < N_CODES; i++) begin
      if (s1.ok && (s1.idx == IDX_W'(i)))
        q_nx[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      q         <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1.ok  <= code_ok;
          s1.idx <= bin;
        end
      end
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          q   <= q_nx;
          err <= !s1.ok;
        end
      end
      // count at accept so stalled codes are never double counted
      if (in_acc && !code_ok && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_onehot_decoder_pipe.sv
// Directed bench for bcd_onehot_decoder_pipe.
// Three instances: default, N_CODES=10, CNT_W=2.
module tb_bcd_onehot_decoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_iv, a_ir, a_ov, a_or, a_err;
  logic [15:0] a_d;
  logic [22:0] a_q;
  logic [7:0]  a_cnt;

  logic        b_iv, b_ir, b_ov, b_or, b_err;
  logic [15:0] b_d;
  logic [9:0]  b_q;
  logic [7:0]  b_cnt;

  logic        c_iv, c_ir, c_ov, c_or, c_err;
  logic [15:0] c_d;
  logic [22:0] c_q;
  logic [1:0]  c_cnt;

  bcd_onehot_decoder_pipe u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_iv), .in_ready(a_ir), .d(a_d),
    .out_valid(a_ov), .out_ready(a_or),
    .q(a_q), .err(a_err), .err_cnt(a_cnt)
  );

  bcd_onehot_decoder_pipe #(.N_CODES(10)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_iv), .in_ready(b_ir), .d(b_d),
    .out_valid(b_ov), .out_ready(b_or),
    .q(b_q), .err(b_err), .err_cnt(b_cnt)
  );

  bcd_onehot_decoder_pipe #(.CNT_W(2)) u_c (
    .clk(clk), .reset(reset),
    .in_valid(c_iv), .in_ready(c_ir), .d(c_d),
    .out_valid(c_ov), .out_ready(c_or),
    .q(c_q), .err(c_err), .err_cnt(c_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  logic [15:0] in_q[$];
  int          exp_in[$];
  int          sb[$];
  int          cyc = 0;
  int          acc_n = 0;
  int          out_n = 0;
  int          first_acc = -1;
  int          first_out = -1;

  function automatic logic [22:0] exq(input int e);
    logic [22:0] one;
    one = 23'd1;
    if (e < 0) return '0;
    return one << e;
  endfunction

  task automatic push(input logic [15:0] code,
                      input int e);
    in_q.push_back(code);
    exp_in.push_back(e);
  endtask

  task automatic step(input logic ordy);
    int e;
    @(negedge clk);
    cyc++;
    a_iv = (in_q.size() > 0);
    a_d  = a_iv ? in_q[0] : 16'h0000;
    a_or = ordy;
    #1;
    if (a_ov && a_or) begin
      if (sb.size() == 0) begin
        chk("stale_out", 32'(a_ov), 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("q_%0d", e), 32'(a_q), 32'(exq(e)));
        chk($sformatf("err_%0d", e), 32'(a_err),
            (e < 0) ? 32'd1 : 32'd0);
        out_n++;
        if (first_out < 0) first_out = cyc;
      end
    end
    if (a_iv && a_ir) begin
      void'(in_q.pop_front());
      sb.push_back(exp_in.pop_front());
      acc_n++;
      if (first_acc < 0) first_acc = cyc;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((in_q.size() > 0 || sb.size() > 0)
           && n < 200) begin
      step(1'b1);
      n++;
    end
    chk("drain_left", 32'(in_q.size() + sb.size()), 32'd0);
  endtask

  int          c_exp[5] = '{1, 2, 3, 3, 3};
  logic [22:0] qhold;
  int          acc0;

  initial begin
    reset = 1'b1;
    a_iv = 0; a_d = 0; a_or = 1;
    b_iv = 0; b_d = 0; b_or = 1;
    c_iv = 0; c_d = 0; c_or = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ov", 32'(a_ov), 32'd0);
    chk("rst_q", 32'(a_q), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_ir", 32'(a_ir), 32'd1);

    // N_CODES=10: 09 is top bit, 10 is out of range
    @(negedge clk);
    b_iv = 1; b_d = 16'h0109;
    #1 chk("b_ir", 32'(b_ir), 32'd1);
    @(negedge clk);
    b_d = 16'h0110;
    @(negedge clk);
    b_iv = 0;
    #1;
    chk("b_ov0", 32'(b_ov), 32'd1);
    chk("b_q0", 32'(b_q), 32'h200);
    chk("b_err0", 32'(b_err), 32'd0);
    @(negedge clk);
    #1;
    chk("b_ov1", 32'(b_ov), 32'd1);
    chk("b_q1", 32'(b_q), 32'd0);
    chk("b_err1", 32'(b_err), 32'd1);
    chk("b_cnt", 32'(b_cnt), 32'd1);
    @(negedge clk);
    #1 chk("b_ov2", 32'(b_ov), 32'd0);

    // CNT_W=2: five invalid codes saturate at 3
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      #1;
      if (i > 0)
        chk($sformatf("c_cnt_%0d", i),
            32'(c_cnt), 32'(c_exp[i-1]));
      if (i == 2) begin
        chk("c_ov", 32'(c_ov), 32'd1);
        chk("c_q", 32'(c_q), 32'd0);
        chk("c_err", 32'(c_err), 32'd1);
        chk("c_ir", 32'(c_ir), 32'd1);
      end
      c_iv = (i < 5);
      c_d  = 16'h0123;
    end

    // full valid stream 00..22
    for (int i = 0; i < 23; i++)
      push({8'h01, 4'(i / 10), 4'(i % 10)}, i);
    drain();
    chk("latency", 32'(first_out - first_acc), 32'd2);
    chk("out_n", 32'(out_n), 32'd23);
    chk("cnt_valid", 32'(a_cnt), 32'd0);

    // invalid codes
    push(16'h0123, -1);
    push(16'h010A, -1);
    push(16'h0200, -1);
    push(16'h01F0, -1);
    drain();
    chk("cnt_inv", 32'(a_cnt), 32'd4);

    // backpressure: only two codes fit
    push(16'h0105, 5);
    push(16'h0107, 7);
    push(16'h0108, 8);
    acc0 = acc_n;
    qhold = '0;
    for (int s = 0; s < 5; s++) begin
      step(1'b0);
      if (s == 2) qhold = a_q;
      if (s >= 2)
        chk($sformatf("stall_ir_%0d", s),
            32'(a_ir), 32'd0);
    end
    chk("stall_acc", 32'(acc_n - acc0), 32'd2);
    chk("stall_ov", 32'(a_ov), 32'd1);
    chk("stall_q", 32'(a_q), 32'(qhold));
    chk("stall_q5", 32'(a_q), 32'h20);
    drain();

    // reset with both stages full
    push(16'h0106, 6);
    push(16'h0133, -1);
    repeat (3) step(1'b0);
    chk("pre_rst_cnt", 32'(a_cnt), 32'd5);
    @(negedge clk);
    reset = 1'b1;
    a_iv  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(a_ov), 32'd0);
    chk("mid_rst_cnt", 32'(a_cnt), 32'd0);
    chk("mid_rst_ir", 32'(a_ir), 32'd1);
    in_q.delete();
    exp_in.delete();
    sb.delete();
    repeat (3) step(1'b1);
    chk("post_rst_ov", 32'(a_ov), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
